// File: rtl/multicycle_alu.sv
// Iterative execute-stage ALU: single-cycle logic/arith, bit-serial shifts, shift-add MUL.
// Optional multiplier datapath enabled by defining ALU_MUL_EN.
module multicycle_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [1:0]       ALUFlags,
    output logic             FlagsWrEn
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] lo_q;     // shift register for SHL/SHR, product low half for MUL
    logic [CW-1:0]    cnt_q;    // remaining iterations
    logic             cy_q;     // last bit shifted out
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] hi_q;     // product high half
    logic [WIDTH:0]   mul_sum;
`endif

    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] fin_result;
    logic             fin_carry;
    logic             fin_wr;

    assign add_full = {1'b0, a_q} + {1'b0, b_q};

`ifdef ALU_MUL_EN
    // One shift-add step: conditionally add A into the high half, then shift right.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
`endif

    // Final result/flag selection once iterations are exhausted.
    always_comb begin
        fin_result = '0;
        fin_carry  = 1'b0;
        fin_wr     = 1'b1;
        case (op_q)
            OP_ADD: begin
                fin_result = add_full[WIDTH-1:0];
                fin_carry  = add_full[WIDTH];
            end
            OP_SUB: begin
                fin_result = a_q - b_q;
                fin_carry  = (a_q < b_q);
            end
            OP_AND: fin_result = a_q & b_q;
            OP_OR:  fin_result = a_q | b_q;
            OP_XOR: fin_result = a_q ^ b_q;
            OP_SHL, OP_SHR: begin
                fin_result = lo_q;
                fin_carry  = cy_q;
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                fin_result = lo_q;
                fin_carry  = |hi_q;
`else
                fin_wr     = 1'b0;
`endif
            end
            default: fin_result = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            cy_q      <= 1'b0;
`ifdef ALU_MUL_EN
            hi_q      <= '0;
`endif
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Result    <= '0;
            ALUFlags  <= 2'b00;
            FlagsWrEn <= 1'b0;
        end else begin
            Done      <= 1'b0;
            FlagsWrEn <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        op_q    <= Op;
                        a_q     <= OperandA;
                        b_q     <= OperandB;
                        cy_q    <= 1'b0;
                        lo_q    <= OperandA;
                        cnt_q   <= '0;
                        Busy    <= 1'b1;
                        state_q <= S_EXEC;
                        if (Op == OP_SHL || Op == OP_SHR) begin
                            cnt_q <= CW'(OperandB[SW-1:0]);
                        end
`ifdef ALU_MUL_EN
                        if (Op == OP_MUL) begin
                            cnt_q <= CW'(WIDTH);
                            hi_q  <= '0;
                            lo_q  <= OperandB;
                        end
`endif
                    end
                end
                S_EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                        case (op_q)
                            OP_SHL: begin
                                cy_q <= lo_q[WIDTH-1];
                                lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                            end
                            OP_SHR: begin
                                cy_q <= lo_q[0];
                                lo_q <= {1'b0, lo_q[WIDTH-1:1]};
                            end
`ifdef ALU_MUL_EN
                            OP_MUL: {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
`endif
                            default: ;
                        endcase
                    end else begin
                        state_q   <= S_DONE;
                        Done      <= 1'b1;
                        FlagsWrEn <= fin_wr;
                        Result    <= fin_result;
                        if (fin_wr) begin
                            ALUFlags <= {fin_carry, (fin_result == '0)};
                        end
                    end
                end
                S_DONE: begin
                    Busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=8): directed steps plus random ops vs. an arithmetic model.
module tb_multicycle_alu;

    logic       Clk;
    logic       Rst_n;
    logic       Start;
    logic [2:0] Op;
    logic [7:0] OperandA;
    logic [7:0] OperandB;
    logic       Busy;
    logic       Done;
    logic [7:0] Result;
    logic [1:0] ALUFlags;
    logic       FlagsWrEn;

    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    logic [1:0] exp_flags = 2'b00;
    logic [7:0] exp_result = 8'h00;

    multicycle_alu #(.WIDTH(8)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .ALUFlags  (ALUFlags),
        .FlagsWrEn (FlagsWrEn)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected result/flags/strobe/latency computed with plain integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic [1:0] prev, output logic [7:0] res,
                                  output logic [1:0] fl, output logic wr, output int lat);
        int   n;
        int   p;
        logic c;
        n   = int'(b[2:0]);
        wr  = 1'b1;
        lat = 1;
        c   = 1'b0;
        p   = 0;
        res = 8'h00;
        case (op)
            3'd0: begin p = int'(a) + int'(b); res = p[7:0]; c = (p > 255); end
            3'd1: begin p = int'(a) - int'(b); res = p[7:0]; c = (int'(a) < int'(b)); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin
                p   = int'(a) << n;
                res = p[7:0];
                c   = (n != 0) && (((int'(a) >> (8 - n)) & 1) != 0);
                lat = n + 1;
            end
            3'd6: begin
                p   = int'(a) >> n;
                res = p[7:0];
                c   = (n != 0) && (((int'(a) >> (n - 1)) & 1) != 0);
                lat = n + 1;
            end
            default: begin
`ifdef ALU_MUL_EN
                p   = int'(a) * int'(b);
                res = p[7:0];
                c   = (p > 255);
                lat = 9;
`else
                res = 8'h00;
                wr  = 1'b0;
`endif
            end
        endcase
        fl = wr ? {c, (res == 8'h00)} : prev;
    endfunction

    // Issue one op from IDLE; optionally pulse a competing Start (sampled at edge intrude_at).
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int intrude_at);
        logic [7:0] er;
        logic [1:0] ef;
        logic       ew;
        int         el;
        int         k;
        model(op, a, b, exp_flags, er, ef, ew, el);
        Op = op; OperandA = a; OperandB = b; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        k = 0;
        for (int c = 1; c <= el + 4; c++) begin
            if (c + 1 == intrude_at) begin
                Start = 1'b1; Op = 3'd0; OperandA = 8'h02; OperandB = 8'h02;
            end
            @(posedge Clk); #1;
            if (c == intrude_at) Start = 1'b0;
            if (Done === 1'b1) begin
                k = c;
                break;
            end
            check({tag, ":busy"}, 32'(Busy), 32'd1);
        end
        Start = 1'b0;
        check({tag, ":latency"}, 32'(k), 32'(el));
        check({tag, ":result"}, 32'(Result), 32'(er));
        check({tag, ":flags"}, 32'(ALUFlags), 32'(ef));
        check({tag, ":wren"}, 32'(FlagsWrEn), 32'(ew));
        exp_flags  = ef;
        exp_result = er;
        if (k != 0) begin
            @(posedge Clk); #1;
            check({tag, ":done_pulse"}, 32'({Done, FlagsWrEn, Busy}), 32'd0);
            check({tag, ":held"}, 32'({Result, ALUFlags}), 32'({er, ef}));
        end
    endtask

    initial begin
        int saw_done;
        Rst_n = 1'b0; Start = 1'b0; Op = 3'd0; OperandA = 8'h00; OperandB = 8'h00;
        #2;
        check("reset_outputs", 32'({Busy, Done, FlagsWrEn, ALUFlags, Result}), 32'd0);
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;
        @(posedge Clk); #1;
        check("idle_after_reset", 32'({Busy, Done, FlagsWrEn}), 32'd0);

        run_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 0);
        run_op("sub_03_05", 3'd1, 8'h03, 8'h05, 0);
        run_op("and_f0_0f", 3'd2, 8'hF0, 8'h0F, 0);
        run_op("shl_81_3",  3'd5, 8'h81, 8'h03, 0);
        run_op("shr_81_1",  3'd6, 8'h81, 8'h01, 0);
        run_op("mul_10_10_ignored_start", 3'd7, 8'h10, 8'h10, 3);
        run_op("add_ff_01b", 3'd0, 8'hFF, 8'h01, 0);
        run_op("mul_after_add", 3'd7, 8'h07, 8'h09, 0);
        run_op("or_a5_5a",  3'd3, 8'hA5, 8'h5A, 0);
        run_op("xor_3c_3c", 3'd4, 8'h3C, 8'h3C, 0);
        run_op("shl_amt0",  3'd5, 8'h80, 8'h08, 0);
        run_op("shr_amt0",  3'd6, 8'h01, 8'h00, 0);
        run_op("shl_01_7_ignored_start", 3'd5, 8'h01, 8'h07, 3);
        run_op("shr_ff_7",  3'd6, 8'hFF, 8'hF7, 0);

        // Reset in the middle of a long operation.
`ifdef ALU_MUL_EN
        Op = 3'd7; OperandA = 8'h10; OperandB = 8'h10;
`else
        Op = 3'd5; OperandA = 8'hFF; OperandB = 8'h07;
`endif
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("midop_reset", 32'({Busy, Done, FlagsWrEn, ALUFlags, Result}), 32'd0);
        @(posedge Clk); #2 Rst_n = 1'b1;
        saw_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge Clk); #1;
            if (Done === 1'b1) saw_done = 1;
        end
        check("midop_no_done", 32'(saw_done), 32'd0);
        exp_flags = 2'b00;
        run_op("add_01_01_after_reset", 3'd0, 8'h01, 8'h01, 0);

        for (int i = 0; i < 60; i++) begin
            run_op("random", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
